// File: rtl/lc_mem_pkg.sv
// lc_mem_pkg: shared definitions for the LC-class unified memory unit.
//   - address-source encodings for req_src
//   - FSM state type (IDLE / WAIT / ACCESS)
//   - byte width of one memory bank
//   - even-parity helper, used only when LC_MEM_PARITY_EN is defined
package lc_mem_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] SRC_PC   = 2'b00;
  localparam logic [1:0] SRC_R6   = 2'b01;
  localparam logic [1:0] SRC_ALU  = 2'b10;
  localparam logic [1:0] SRC_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ACCESS = 2'b10
  } state_e;

  // Parity bit that makes the byte plus the bit an even number of ones.
  function automatic logic even_parity(input logic [BYTE_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/lc_mem_if.sv
// lc_mem_if: request/response bundle between the LC datapath and lc_mem_unit.
//   master : datapath side (drives request fields, pc/r6/alu_out, wdata)
//   slave  : memory side (drives req_ready, ir, mdr, resp_valid, misalign_err)
// parity_err exists only when LC_MEM_PARITY_EN is defined.
interface lc_mem_if #(
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_src;
  logic [15:0]       pc;
  logic [15:0]       r6;
  logic [15:0]       alu_out;
  logic              req_we;
  logic              req_word;
  logic              req_lane;
  logic              req_ir;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mdr;
  logic              resp_valid;
  logic              misalign_err;
`ifdef LC_MEM_PARITY_EN
  logic              parity_err;
`endif

  modport master (
    output req_valid, req_src, pc, r6, alu_out, req_we, req_word, req_lane,
           req_ir, wdata,
    input  req_ready, ir, mdr, resp_valid, misalign_err
`ifdef LC_MEM_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  req_valid, req_src, pc, r6, alu_out, req_we, req_word, req_lane,
           req_ir, wdata,
    output req_ready, ir, mdr, resp_valid, misalign_err
`ifdef LC_MEM_PARITY_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/lc_mem_bank.sv
// lc_mem_bank: one byte-wide bank of the unified memory, DEPTH_WORDS deep.
//   clk   : rising-edge clock
//   we    : synchronous write enable
//   idx   : word index
//   wdata : byte to write
//   rdata : combinational read of mem[idx]
//   wpar/rpar : stored parity bit (only with LC_MEM_PARITY_EN)
// Contents are deliberately not reset.
module lc_mem_bank
  import lc_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [BYTE_W-1:0]              wdata,
  output logic [BYTE_W-1:0]              rdata
`ifdef LC_MEM_PARITY_EN
  ,
  input  logic                           wpar,
  output logic                           rpar
`endif
);

  logic [BYTE_W-1:0] mem_r [DEPTH_WORDS];

  // Byte storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[idx] <= wdata;
    end
  end

  assign rdata = mem_r[idx];

`ifdef LC_MEM_PARITY_EN
  logic par_r [DEPTH_WORDS];

  // Parity storage write port, written alongside every byte store
  always_ff @(posedge clk) begin
    if (we) begin
      par_r[idx] <= wpar;
    end
  end

  assign rpar = par_r[idx];
`endif

endmodule

// File: rtl/lc_mem_unit.sv
// lc_mem_unit: handshaked byte-addressable unified memory for the LC datapath.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any transaction in flight
//   bus   : lc_mem_if.slave (request fields, pc/r6/alu_out, wdata in;
//           req_ready, ir, mdr, resp_valid, misalign_err out)
// Optional build macro LC_MEM_PARITY_EN adds per-byte even parity and
// bus.parity_err.
// Timing: accept edge -> WAIT_CYCLES wait edges -> access edge; resp_valid is
// registered on the access edge so it is seen WAIT_CYCLES+1 cycles after accept.
module lc_mem_unit
  import lc_mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  lc_mem_if.slave bus
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int ADDR_W = IDX_W + 1;
  localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic              word_r;
  logic              lane_r;
  logic              to_ir_r;
  logic [DATA_W-1:0] wdata_r;
  logic              ready_r;
  logic              resp_r;
  logic              mis_r;
  logic [DATA_W-1:0] ir_r;
  logic [DATA_W-1:0] mdr_r;

  logic [ADDR_W-1:0] addr_s;
  logic              odd_s;
  logic              mis_s;
  logic              access_s;
  logic              wr_lo_s;
  logic              wr_hi_s;
  logic [BYTE_W-1:0] wdat_hi_s;
  logic [BYTE_W-1:0] rd_lo_s;
  logic [BYTE_W-1:0] rd_hi_s;
  logic [BYTE_W-1:0] rd_byte_s;

  // Request address mux; only the bits that reach the banks are kept
  always_comb begin
    addr_s = '0;
    case (bus.req_src)
      SRC_PC:   addr_s = bus.pc[ADDR_W-1:0];
      SRC_R6:   addr_s = bus.r6[ADDR_W-1:0];
      SRC_ALU:  addr_s = bus.alu_out[ADDR_W-1:0];
      SRC_ZERO: addr_s = '0;
      default:  addr_s = '0;
    endcase
  end

  assign odd_s     = addr_r[0];
  assign mis_s     = word_r & odd_s;
  // Reset on the access edge must suppress the write, so it gates the enables.
  assign access_s  = (state_r == ST_ACCESS) & ~reset;
  assign wr_lo_s   = access_s & we_r & ~mis_s & (word_r | ~odd_s);
  assign wr_hi_s   = access_s & we_r & ~mis_s & (word_r | odd_s);
  // A byte store always takes wdata[7:0], whichever bank it lands in.
  assign wdat_hi_s = word_r ? wdata_r[DATA_W-1:BYTE_W] : wdata_r[BYTE_W-1:0];
  assign rd_byte_s = odd_s ? rd_hi_s : rd_lo_s;

`ifdef LC_MEM_PARITY_EN
  logic rpar_lo_s;
  logic rpar_hi_s;
  logic bad_lo_s;
  logic bad_hi_s;
  logic par_bad_s;
  logic par_err_r;

  assign bad_lo_s  = rpar_lo_s ^ even_parity(rd_lo_s);
  assign bad_hi_s  = rpar_hi_s ^ even_parity(rd_hi_s);
  assign par_bad_s = word_r ? (bad_lo_s | bad_hi_s) : (odd_s ? bad_hi_s : bad_lo_s);
`endif

  lc_mem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank_lo (
    .clk   (clk),
    .we    (wr_lo_s),
    .idx   (addr_r[ADDR_W-1:1]),
    .wdata (wdata_r[BYTE_W-1:0]),
    .rdata (rd_lo_s)
`ifdef LC_MEM_PARITY_EN
    ,
    .wpar  (even_parity(wdata_r[BYTE_W-1:0])),
    .rpar  (rpar_lo_s)
`endif
  );

  lc_mem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank_hi (
    .clk   (clk),
    .we    (wr_hi_s),
    .idx   (addr_r[ADDR_W-1:1]),
    .wdata (wdat_hi_s),
    .rdata (rd_hi_s)
`ifdef LC_MEM_PARITY_EN
    ,
    .wpar  (even_parity(wdat_hi_s)),
    .rpar  (rpar_hi_s)
`endif
  );

  // Transaction FSM with registered handshake, response and load results
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      addr_r  <= '0;
      we_r    <= 1'b0;
      word_r  <= 1'b0;
      lane_r  <= 1'b0;
      to_ir_r <= 1'b0;
      wdata_r <= '0;
      ready_r <= 1'b1;
      resp_r  <= 1'b0;
      mis_r   <= 1'b0;
      ir_r    <= '0;
      mdr_r   <= '0;
`ifdef LC_MEM_PARITY_EN
      par_err_r <= 1'b0;
`endif
    end else begin
      resp_r <= 1'b0;
      mis_r  <= 1'b0;
`ifdef LC_MEM_PARITY_EN
      par_err_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            addr_r  <= addr_s;
            we_r    <= bus.req_we;
            word_r  <= bus.req_word;
            lane_r  <= bus.req_lane;
            to_ir_r <= bus.req_ir;
            wdata_r <= bus.wdata;
            ready_r <= 1'b0;
            cnt_r   <= WAIT_INIT;
            state_r <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          if (cnt_r == '0) begin
            state_r <= ST_ACCESS;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_ACCESS: begin
          resp_r  <= 1'b1;
          mis_r   <= mis_s;
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
          if (!mis_s && !we_r) begin
            if (word_r && to_ir_r) begin
              ir_r <= {rd_hi_s, rd_lo_s};
            end else if (word_r) begin
              mdr_r <= {rd_hi_s, rd_lo_s};
            end else if (lane_r) begin
              // IR byte loads are illegal and fall through to MDR here.
              mdr_r <= {rd_byte_s, {BYTE_W{1'b0}}};
            end else begin
              mdr_r <= {{BYTE_W{1'b0}}, rd_byte_s};
            end
`ifdef LC_MEM_PARITY_EN
            par_err_r <= par_bad_s;
`endif
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready    = ready_r;
  assign bus.resp_valid   = resp_r;
  assign bus.misalign_err = mis_r;
  assign bus.ir           = ir_r;
  assign bus.mdr          = mdr_r;
`ifdef LC_MEM_PARITY_EN
  assign bus.parity_err   = par_err_r;
`endif

endmodule

// File: tb/tb_lc_mem_unit.sv
// tb_lc_mem_unit: directed self-checking bench for lc_mem_unit.
// u_dut1 runs with WAIT_CYCLES=1, u_dut0 with WAIT_CYCLES=0 (both 256 words).
module tb_lc_mem_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  lc_mem_if #(.DATA_W(16)) if1 ();
  lc_mem_if #(.DATA_W(16)) if0 ();

  lc_mem_unit #(.DATA_W(16), .DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  lc_mem_unit #(.DATA_W(16), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request on the chosen DUT; the unselected address sources carry
  // decoys that map to other words. Checks ready, latency and misalign.
  task automatic do_req(input bit d0, input logic [1:0] src, input logic [15:0] a,
                        input logic we, input logic word, input logic lane,
                        input logic irf, input logic [15:0] wd,
                        input int exp_lat, input logic exp_mis, input string tag);
    logic [15:0] pcv, r6v, aluv;
    logic rdy, seen, mis;
    int lat;
    pcv  = (src == 2'd0) ? a : (a ^ 16'h0040);
    r6v  = (src == 2'd1) ? a : (a ^ 16'h0080);
    aluv = (src == 2'd2) ? a : (a ^ 16'h00C0);
    @(negedge clk);
    if (d0) begin
      if0.req_src = src; if0.pc = pcv; if0.r6 = r6v; if0.alu_out = aluv;
      if0.req_we = we; if0.req_word = word; if0.req_lane = lane;
      if0.req_ir = irf; if0.wdata = wd; if0.req_valid = 1'b1;
      rdy = if0.req_ready;
    end else begin
      if1.req_src = src; if1.pc = pcv; if1.r6 = r6v; if1.alu_out = aluv;
      if1.req_we = we; if1.req_word = word; if1.req_lane = lane;
      if1.req_ir = irf; if1.wdata = wd; if1.req_valid = 1'b1;
      rdy = if1.req_ready;
    end
    check_val({tag, "_ready"}, 32'(rdy), 32'd1);
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    if1.req_valid = 1'b0;
    seen = 1'b0;
    mis  = 1'b0;
    lat  = 0;
    while (!seen && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      seen = d0 ? if0.resp_valid : if1.resp_valid;
      mis  = d0 ? if0.misalign_err : if1.misalign_err;
    end
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_mis"}, 32'(mis), 32'(exp_mis));
`ifdef LC_MEM_PARITY_EN
    check_val({tag, "_par"}, 32'(d0 ? if0.parity_err : if1.parity_err), 32'd0);
`endif
  endtask

  initial begin : stim
    int n_resp;
    if1.req_valid = 1'b0; if1.req_src = 2'd0; if1.pc = 16'h0; if1.r6 = 16'h0;
    if1.alu_out = 16'h0; if1.req_we = 1'b0; if1.req_word = 1'b0;
    if1.req_lane = 1'b0; if1.req_ir = 1'b0; if1.wdata = 16'h0;
    if0.req_valid = 1'b0; if0.req_src = 2'd0; if0.pc = 16'h0; if0.r6 = 16'h0;
    if0.alu_out = 16'h0; if0.req_we = 1'b0; if0.req_word = 1'b0;
    if0.req_lane = 1'b0; if0.req_ir = 1'b0; if0.wdata = 16'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("rst_ir",    32'(if1.ir), 32'h0);
    check_val("rst_mdr",   32'(if1.mdr), 32'h0);
    check_val("rst_resp",  32'(if1.resp_valid), 32'd0);
    check_val("rst_mis",   32'(if1.misalign_err), 32'd0);
    check_val("rst_ready", 32'(if1.req_ready), 32'd1);

    // Word store / load round trip through the ALU source
    do_req(1'b0, 2'd2, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 2, 1'b0, "st_beef");
    do_req(1'b0, 2'd2, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2, 1'b0, "ld_beef");
    check_val("ld_beef_mdr", 32'(if1.mdr), 32'hBEEF);

    // Byte store into high bank, byte loads to both lanes, low byte kept
    do_req(1'b0, 2'd2, 16'h0020, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 2, 1'b0, "st_1234");
    do_req(1'b0, 2'd2, 16'h0021, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFF5A, 2, 1'b0, "stb_5a");
    do_req(1'b0, 2'd2, 16'h0021, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2, 1'b0, "ldb_l0");
    check_val("ldb_l0_mdr", 32'(if1.mdr), 32'h005A);
    do_req(1'b0, 2'd2, 16'h0021, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2, 1'b0, "ldb_l1");
    check_val("ldb_l1_mdr", 32'(if1.mdr), 32'h5A00);
    do_req(1'b0, 2'd2, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 2, 1'b0, "ldb_lo");
    check_val("ldb_lo_mdr", 32'(if1.mdr), 32'h0034);
    check_val("ldb_lo_ir",  32'(if1.ir), 32'h0);
    do_req(1'b0, 2'd2, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2, 1'b0, "ld_5a34");
    check_val("ld_5a34_mdr", 32'(if1.mdr), 32'h5A34);

    // Instruction fetch through PC leaves MDR alone
    do_req(1'b0, 2'd2, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1401, 2, 1'b0, "st_1401");
    do_req(1'b0, 2'd0, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 2, 1'b0, "fetch");
    check_val("fetch_ir",  32'(if1.ir), 32'h1401);
    check_val("fetch_mdr", 32'(if1.mdr), 32'h5A34);

    // Misaligned word load and store
    do_req(1'b0, 2'd2, 16'h0011, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2, 1'b1, "mis_ld");
    check_val("mis_ld_mdr", 32'(if1.mdr), 32'h5A34);
    do_req(1'b0, 2'd2, 16'h0012, 1'b1, 1'b1, 1'b0, 1'b0, 16'hCAFE, 2, 1'b0, "st_cafe");
    do_req(1'b0, 2'd2, 16'h0013, 1'b1, 1'b1, 1'b0, 1'b0, 16'hDEAD, 2, 1'b1, "mis_st");
    do_req(1'b0, 2'd2, 16'h0012, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2, 1'b0, "ld_w9");
    check_val("ld_w9_mdr", 32'(if1.mdr), 32'hCAFE);

    // req_valid held through WAIT with a new address must be ignored
    do_req(1'b0, 2'd2, 16'h0032, 1'b1, 1'b1, 1'b0, 1'b0, 16'h3333, 2, 1'b0, "st_3333");
    @(negedge clk);
    if1.req_src = 2'd2; if1.alu_out = 16'h0030; if1.req_we = 1'b1;
    if1.req_word = 1'b1; if1.wdata = 16'h1111; if1.req_valid = 1'b1;
    @(posedge clk); #1;
    check_val("busy_ready", 32'(if1.req_ready), 32'd0);
    if1.alu_out = 16'h0032;
    if1.wdata   = 16'h2222;
    n_resp = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (if1.resp_valid) begin
        n_resp++;
        if1.req_valid = 1'b0;
        break;
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (if1.resp_valid) n_resp++;
    end
    check_val("busy_nresp", 32'(n_resp), 32'd1);
    do_req(1'b0, 2'd2, 16'h0030, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2, 1'b0, "ld_1111");
    check_val("ld_1111_mdr", 32'(if1.mdr), 32'h1111);
    do_req(1'b0, 2'd2, 16'h0032, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2, 1'b0, "ld_3333");
    check_val("ld_3333_mdr", 32'(if1.mdr), 32'h3333);

    // Reset during WAIT of a store aborts it
    @(negedge clk);
    if1.req_src = 2'd2; if1.alu_out = 16'h0030; if1.req_we = 1'b1;
    if1.req_word = 1'b1; if1.wdata = 16'h7777; if1.req_valid = 1'b1;
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_resp = 0;
    if (if1.resp_valid) n_resp++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (if1.resp_valid) n_resp++;
    end
    check_val("abort_nresp", 32'(n_resp), 32'd0);
    check_val("abort_ready", 32'(if1.req_ready), 32'd1);
    check_val("abort_mdr",   32'(if1.mdr), 32'h0);
    do_req(1'b0, 2'd2, 16'h0030, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2, 1'b0, "ld_abort");
    check_val("ld_abort_mdr", 32'(if1.mdr), 32'h1111);

    // Zero wait states: R6 store wraps onto word 1, address-0 source
    do_req(1'b1, 2'd1, 16'h0202, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA55A, 1, 1'b0, "w0_st");
    do_req(1'b1, 2'd2, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 1'b0, "w0_ld");
    check_val("w0_ld_mdr", 32'(if0.mdr), 32'hA55A);
    do_req(1'b1, 2'd3, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0F0F, 1, 1'b0, "w0_st0");
    do_req(1'b1, 2'd2, 16'h0200, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 1'b0, "w0_ld0");
    check_val("w0_ld0_mdr", 32'(if0.mdr), 32'h0F0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
